// File: rtl/ppe_pkg.sv
// Shared types for the round-robin scheduler wrapped around the
// 1024-input programmable priority encoder.
package ppe_pkg;
  localparam int WIDTH = 1024;
  localparam int IDX_W = 10;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    OFFER
  } state_e;
endpackage

// File: rtl/ppe_pend_vec.sv
// Pending-request vector with set-over-clear priority and an incrementally
// maintained population count.
module ppe_pend_vec #(
  parameter int WIDTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_valid_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic             clr_valid_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  output logic [WIDTH-1:0] pend_o,
  output logic [IDX_W:0]   pend_cnt_o
);
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             set_new, clr_eff;

  always_comb begin
    // A set to an already pending bit is a no-op; a clear that collides
    // with a set to the same index loses, so the requester stays queued.
    set_new = set_valid_i && !pend_q[set_idx_i];
    clr_eff = clr_valid_i && pend_q[clr_idx_i] &&
              !(set_valid_i && (set_idx_i == clr_idx_i));
    pend_d  = pend_q;
    if (clr_eff)     pend_d[clr_idx_i] = 1'b0;
    if (set_valid_i) pend_d[set_idx_i] = 1'b1;
    cnt_d = cnt_q + (IDX_W+1)'(set_new) - (IDX_W+1)'(clr_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o     = pend_q;
  assign pend_cnt_o = cnt_q;
endmodule

// File: rtl/ppe_rr_sched.sv
// Round-robin scheduler: snapshots pending requests into the external
// priority encoder, then offers the winner on a valid/ready grant port.
module ppe_rr_sched
  import ppe_pkg::*;
#(
  parameter int WIDTH   = ppe_pkg::WIDTH,
  parameter int IDX_W   = ppe_pkg::IDX_W,
  parameter int PPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_valid,
  input  logic [IDX_W-1:0] set_idx,
  output logic [WIDTH-1:0] ppe_req,
  output logic [IDX_W-1:0] ppe_penc,
  input  logic [IDX_W-1:0] ppe_value,
  input  logic [IDX_W-1:0] ppe_value_inc,
  input  logic             ppe_valid,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  input  logic             gnt_ready,
  output logic [IDX_W:0]   pend_cnt
);
  localparam int WCW = (PPE_LAT < 2) ? 1 : $clog2(PPE_LAT + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] req_q, req_d;
  logic [IDX_W-1:0] penc_q, penc_d;
  logic [IDX_W-1:0] nxt_ptr_q, nxt_ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [WIDTH-1:0] pend;
  logic             hs;

  assign hs = (state_q == OFFER) && gnt_valid_q && gnt_ready;

  ppe_pend_vec #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_pend (
    .clk         (clk),
    .rst         (rst),
    .set_valid_i (set_valid),
    .set_idx_i   (set_idx),
    .clr_valid_i (hs),
    .clr_idx_i   (gnt_idx_q),
    .pend_o      (pend),
    .pend_cnt_o  (pend_cnt)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    penc_d      = penc_q;
    nxt_ptr_d   = nxt_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    wait_d      = wait_q;
    unique case (state_q)
      IDLE: begin
        if (|pend) state_d = LAUNCH;
      end
      LAUNCH: begin
        // Encoder inputs are frozen from here until the result is sampled.
        req_d   = pend;
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wait_d = wait_q + WCW'(1);
        if (wait_q == WCW'(PPE_LAT - 1)) begin
          if (ppe_valid) begin
            gnt_idx_d   = ppe_value;
            nxt_ptr_d   = ppe_value_inc;
            gnt_valid_d = 1'b1;
            state_d     = OFFER;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OFFER: begin
        if (gnt_ready) begin
          gnt_valid_d = 1'b0;
          penc_d      = nxt_ptr_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      penc_q      <= '0;
      nxt_ptr_q   <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      penc_q      <= penc_d;
      nxt_ptr_q   <= nxt_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      wait_q      <= wait_d;
    end
  end

  assign ppe_req   = req_q;
  assign ppe_penc  = penc_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
endmodule

// File: tb/tb_ppe_rr_sched.sv
// Bench for ppe_rr_sched: behavioural encoder plus a set-based reference
// model of pending requests, pointer and snapshot timing.
module tb_ppe_rr_sched;
  localparam int WIDTH   = 1024;
  localparam int IDX_W   = 10;
  localparam int PPE_LAT = 2;

  logic             clk = 1'b0;
  logic             rst, set_valid, gnt_ready;
  logic [IDX_W-1:0] set_idx;
  logic [WIDTH-1:0] ppe_req;
  logic [IDX_W-1:0] ppe_penc, ppe_value, ppe_value_inc, gnt_idx;
  logic             ppe_valid, gnt_valid;
  logic [IDX_W:0]   pend_cnt;

  ppe_rr_sched #(.WIDTH(WIDTH), .IDX_W(IDX_W), .PPE_LAT(PPE_LAT)) dut (
    .clk(clk), .rst(rst), .set_valid(set_valid), .set_idx(set_idx),
    .ppe_req(ppe_req), .ppe_penc(ppe_penc), .ppe_value(ppe_value),
    .ppe_value_inc(ppe_value_inc), .ppe_valid(ppe_valid),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_ready(gnt_ready),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // First set bit at or after pointer p, rotating; {found, index}.
  function automatic logic [IDX_W:0] find_first(input logic [WIDTH-1:0] v, input int p);
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      j = (p + i) % WIDTH;
      if (v[j]) return {1'b1, IDX_W'(j)};
    end
    return '0;
  endfunction

  // Encoder model: one register stage, so results are valid PPE_LAT cycles
  // after the inputs change.
  logic [IDX_W:0] enc_q = '0;
  always @(posedge clk) enc_q <= find_first(ppe_req, int'(ppe_penc));
  assign ppe_value     = enc_q[IDX_W-1:0];
  assign ppe_valid     = enc_q[IDX_W];
  assign ppe_value_inc = ppe_value + {{(IDX_W-1){1'b0}}, 1'b1};

  int               vecs = 0;
  int               errs = 0;
  logic [WIDTH-1:0] m_pend = '0;
  int               m_ptr = 0;
  logic [WIDTH-1:0] hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs applied this cycle, then
  // check the DUT against it just after the edge.
  task automatic step();
    logic             hs, sv, r, pgv;
    logic [IDX_W-1:0] gi, si;
    logic [WIDTH-1:0] snap;
    logic [IDX_W:0]   exp;
    r   = rst;
    pgv = gnt_valid;
    hs  = !r && gnt_valid && gnt_ready;
    gi  = gnt_idx;
    sv  = set_valid;
    si  = set_idx;
    @(posedge clk);
    #1;
    if (r) begin
      m_pend = '0;
      m_ptr  = 0;
    end else begin
      if (hs) begin
        m_pend[gi] = 1'b0;
        m_ptr      = (int'(gi) + 1) % WIDTH;
      end
      if (sv) m_pend[si] = 1'b1;
    end
    hist.push_back(m_pend);
    if (hist.size() > 8) void'(hist.pop_front());
    chk("pend_cnt", 32'(pend_cnt), $countones(m_pend));
    chk("ppe_penc", 32'(ppe_penc), m_ptr);
    if (!r) begin
      if (hs) begin
        chk("gnt_drop", 32'(gnt_valid), 0);
      end else if (pgv === 1'b1) begin
        chk("gnt_hold_v", 32'(gnt_valid), 1);
        chk("gnt_hold_idx", 32'(gnt_idx), 32'(gi));
      end else if (gnt_valid === 1'b1) begin
        // Snapshot was taken in the LAUNCH cycle, PPE_LAT+1 cycles ago.
        snap = (hist.size() >= PPE_LAT + 2) ? hist[hist.size()-2-PPE_LAT] : '0;
        exp  = find_first(snap, m_ptr);
        chk("gnt_found", 32'(exp[IDX_W]), 1);
        chk("gnt_idx", 32'(gnt_idx), 32'(exp[IDX_W-1:0]));
      end
    end
  endtask

  task automatic do_set(input int idx);
    set_valid = 1'b1;
    set_idx   = IDX_W'(idx);
    step();
    set_valid = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_gv(input int maxc, output int n);
    n = 0;
    while (gnt_valid !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    chk("wait_gnt", 32'(gnt_valid), 1);
  endtask

  task automatic accept();
    gnt_ready = 1'b1;
    step();
    gnt_ready = 1'b0;
  endtask

  int n;
  int exp_seq[4] = '{0, 3, 5, 8};

  initial begin
    rst = 1'b1; set_valid = 1'b0; set_idx = '0; gnt_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_gv", 32'(gnt_valid), 0);
    chk("rst_gidx", 32'(gnt_idx), 0);
    chk("rst_req", $countones(ppe_req), 0);

    // Four requests from pointer 0, served in index order.
    do_set(0); do_set(3); do_set(5); do_set(8);
    chk("lat_t4", 32'(gnt_valid), 0);
    step();
    chk("lat_t5", 32'(gnt_valid), 1);
    for (int k = 0; k < 4; k++) begin
      wait_gv(20, n);
      if (k > 0) chk("thruput", n, PPE_LAT + 2);
      chk("seq_idx", 32'(gnt_idx), exp_seq[k]);
      accept();
      chk("seq_penc", 32'(ppe_penc), exp_seq[k] + 1);
    end
    chk("seq_cnt0", 32'(pend_cnt), 0);

    // Wrap: 0 first, then 1023, pointer returns to 0.
    do_rst();
    do_set(1023); do_set(0);
    wait_gv(20, n); chk("wrap_a", 32'(gnt_idx), 0); accept();
    chk("wrap_pa", 32'(ppe_penc), 1);
    wait_gv(20, n); chk("wrap_b", 32'(gnt_idx), 1023); accept();
    chk("wrap_pb", 32'(ppe_penc), 0);
    repeat (8) step();
    chk("wrap_idle", 32'(gnt_valid), 0);

    // Set and grant-clear of the same index in one cycle: set wins.
    do_rst();
    do_set(5); do_set(9);
    wait_gv(20, n); chk("sw_first", 32'(gnt_idx), 5);
    set_valid = 1'b1; set_idx = 10'd5; gnt_ready = 1'b1;
    step();
    set_valid = 1'b0; gnt_ready = 1'b0;
    chk("sw_cnt", 32'(pend_cnt), 2);
    wait_gv(20, n); chk("sw_9", 32'(gnt_idx), 9); accept();
    wait_gv(20, n); chk("sw_5", 32'(gnt_idx), 5); accept();

    // Back-pressure with sets arriving during the offer.
    do_rst();
    do_set(3);
    wait_gv(20, n); chk("bp_first", 32'(gnt_idx), 3);
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin set_valid = 1'b1; set_idx = 10'd2; end
      else if (k == 2) begin set_valid = 1'b1; set_idx = 10'd7; end
      else set_valid = 1'b0;
      step();
      chk("bp_idx", 32'(gnt_idx), 3);
    end
    set_valid = 1'b0;
    accept();
    wait_gv(20, n); chk("bp_7", 32'(gnt_idx), 7); accept();
    wait_gv(20, n); chk("bp_2", 32'(gnt_idx), 2); accept();

    // Reset during OFFER abandons the grant.
    do_set(4);
    wait_gv(20, n);
    do_rst();
    chk("ro_gv", 32'(gnt_valid), 0);
    chk("ro_gidx", 32'(gnt_idx), 0);
    chk("ro_req", $countones(ppe_req), 0);
    do_set(9);
    wait_gv(20, n);
    chk("ro_lat", n, PPE_LAT + 2);
    chk("ro_9", 32'(gnt_idx), 9);
    accept();

    // Duplicate set gives one pending entry and one grant.
    do_set(4); do_set(4);
    chk("dup_cnt", 32'(pend_cnt), 1);
    wait_gv(20, n); chk("dup_4", 32'(gnt_idx), 4); accept();
    repeat (10) step();
    chk("dup_none", 32'(gnt_valid), 0);

    // Randomized traffic, clustered near both ends to exercise wrap.
    do_rst();
    for (int c = 0; c < 2000; c++) begin
      set_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) set_idx = IDX_W'($urandom_range(0, WIDTH - 1));
      else set_idx = IDX_W'($urandom_range(1008, 1039) % WIDTH);
      gnt_ready = ($urandom_range(0, 1) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    set_valid = 1'b0; rst = 1'b0; gnt_ready = 1'b1;
    n = 0;
    while ((pend_cnt != 0 || gnt_valid) && n < 20000) begin
      step();
      n++;
    end
    chk("drain_cnt", 32'(pend_cnt), 0);
    gnt_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ppe_rr_sched.md
# ppe_rr_sched

Round-robin request scheduler wrapped around the 1024-input programmable priority encoder `ppe_w1024_p`. It collects per-index requests into a pending vector and drives `Req` and `P_enc` into the encoder. After the encoder's pipeline latency it captures the winning index and offers it downstream on a valid/ready grant port. On acceptance it clears the granted request and moves the search pointer to `o_value_inc`, which gives fair rotating service across all 1024 requesters.

## Interface
- `WIDTH`, default 1024: number of requesters; equals the encoder width.
- `IDX_W`, default 10: index width; `WIDTH == 2**IDX_W`.
- `PPE_LAT`, default 2: cycles from a `Req`/`P_enc` change to a valid encoder output. Must be ≥1.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `set_valid` input 1: request-set strobe.
- `set_idx` input IDX_W: index of the requester to mark pending.
- `ppe_req` output WIDTH: snapshot driven to the encoder's `Req`.
- `ppe_penc` output IDX_W: search pointer driven to the encoder's `P_enc`.
- `ppe_value` input IDX_W: encoder `o_value`.
- `ppe_value_inc` input IDX_W: encoder `o_value_inc`, equal to `o_value + 1` mod WIDTH.
- `ppe_valid` input 1: encoder `valid`.
- `gnt_valid` output 1: a grant is offered.
- `gnt_idx` output IDX_W: the granted index.
- `gnt_ready` input 1: downstream accepts the grant.
- `pend_cnt` output IDX_W+1: number of pending requests, 0..WIDTH.

## Operation
- `pend[WIDTH-1:0]` holds the pending requests. A set strobe marks one bit: `pend[set_idx] <= 1` when `set_valid` is high.
- Setting a bit that is already pending has no effect, and `pend_cnt` does not change.
- The grant handshake clears `pend[gnt_idx]`.
- If a set and a grant-clear hit the same index in the same cycle, the set wins: the bit stays 1 and the requester is re-queued.
- `pend_cnt` tracks the population of `pend` incrementally: +1 for a new set, −1 for a clear, net 0 for set-wins.
- FSM states:
  - IDLE: if `pend != 0`, go to LAUNCH.
  - LAUNCH: one cycle. `ppe_req <= pend`; `wait_cnt <= 0`; go to WAIT.
  - WAIT: `wait_cnt` increments each cycle. When `wait_cnt == PPE_LAT-1`, sample the encoder:
    - if `ppe_valid`: `gnt_idx <= ppe_value`, `nxt_ptr <= ppe_value_inc`, go to OFFER;
    - otherwise go to IDLE. This is defensive only and must not occur.
  - OFFER: `gnt_valid` is high. On `gnt_valid && gnt_ready`, clear the bit, set `ppe_penc <= nxt_ptr`, and go to IDLE.
- `ppe_req` and `ppe_penc` are held constant through WAIT, so the encoder sees a stable input. New sets land in `pend` only and are picked up at the next LAUNCH.
- Pointer wrap is handled by the encoder: `ppe_value_inc` of 1023 is 0. The block does no extra arithmetic on it.
- Reset values: state IDLE, `pend=0`, `pend_cnt=0`, `ppe_req=0`, `ppe_penc=0`, `gnt_valid=0`, `gnt_idx=0`, `wait_cnt=0`. Reset in any state, including OFFER, abandons the grant with no handshake.

## Timing
- Set at cycle t: `pend` updates at t+1, LAUNCH at t+2, `ppe_req` is valid at t+3, and the encoder output is sampled at t+2+PPE_LAT.
- `gnt_valid` rises at t+3+PPE_LAT. With PPE_LAT=2 that is t+5.
- `gnt_valid` and `gnt_idx` stay stable while `gnt_ready` is low; no retraction.
- After a handshake at H: IDLE at H+1, LAUNCH at H+2 if `pend` is still nonzero, and the next `gnt_valid` at H+3+PPE_LAT. Throughput is one grant per PPE_LAT+3 cycles.
- `gnt_ready` is ignored outside OFFER.
- `pend_cnt` is registered and reflects `pend` in the same cycle.

## Structure
- Package `ppe_pkg` holds:
  - `WIDTH` and `IDX_W` localparams;
  - the state enum `{IDLE, LAUNCH, WAIT, OFFER}`;
  - the `idx_t` typedef, `logic [IDX_W-1:0]`.
- One sub-module, `ppe_pend_vec`: the pending register with set/clear priority and the incremental `pend_cnt`.
- The FSM, pointer and grant registers live in the top. The encoder is instantiated at the level above.

## Test plan
- Pointer 0; set indices 0, 3, 5, 8 together → grants 0, 3, 5, 8 in order. `ppe_penc` after each handshake is 1, 4, 6, 9. `pend_cnt` goes 4→0.
- Set 1023 and 0 from reset → grant 0 (`ppe_penc`=1), then 1023 (`ppe_penc` wraps to 0). Then IDLE with `gnt_valid`=0.
- Set 5 while `gnt_idx`=5 is in OFFER, with the handshake in the same cycle → bit 5 stays pending. The next grant is 5 after any other pending index ≥6 in rotation. `pend_cnt` is unchanged.
- In OFFER with `gnt_idx`=3, hold `gnt_ready` low for 10 cycles while setting 2 and 7 → `gnt_idx` stays 3 throughout. After accept, the next grant is 7, then 2.
- Assert `rst` during OFFER → next cycle all outputs are at reset values and `pend`=0. A later set of 9 → grant 9 at t+5 (PPE_LAT=2).
- Set index 4 twice in consecutive cycles → `pend_cnt`=1 and exactly one grant of 4.
